// File: rtl/sub_divider_if.sv
// sub_divider_if -- host-side bundle for the repeated-subtraction divider.
//
// Signals:
//   start        host -> divider  request pulse, honoured only while the divider is idle
//   dividend     host -> divider  unsigned dividend, captured with an accepted start
//   divisor      host -> divider  unsigned divisor, captured with an accepted start
//   busy         divider -> host  high while subtraction steps are running
//   done         divider -> host  one-cycle pulse, results valid
//   quotient     divider -> host  result quotient
//   remainder    divider -> host  result remainder
//   div_by_zero  divider -> host  last operation had a zero divisor
//   cycles       divider -> host  subtraction cycles of the last operation
//                                 (only with SUB_DIVIDER_CYCLE_COUNT_EN defined)
//
// Modports: master = host side, slave = divider side.
interface sub_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
    logic [WIDTH:0]   cycles;
`endif

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
        input  cycles,
`endif
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
        output cycles,
`endif
        output div_by_zero
    );
endinterface

// File: rtl/sub_divider.sv
// sub_divider -- unsigned divider by repeated subtraction (datapath + FSM).
//
// Each SUB cycle subtracts the divisor from the working remainder and counts
// one quotient step, until the remainder drops below the divisor. A zero
// divisor finishes after a single SUB cycle with quotient all ones, the
// dividend as remainder and div_by_zero set.
//
// Ports:
//   clk  system clock, rising edge
//   clr  asynchronous active-high clear; forces IDLE and zeroes every register
//   bus  sub_divider_if.slave: start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out
//
// Optional feature: SUB_DIVIDER_CYCLE_COUNT_EN adds bus.cycles, the number of
// clock cycles spent in SUB by the last completed operation.
module sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         clr,
    sub_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;         // working remainder
    logic [WIDTH-1:0] b_q, b_d;         // captured divisor
    logic [WIDTH-1:0] q_q, q_d;         // quotient counter
    logic [WIDTH-1:0] quot_q, quot_d;   // result registers, loaded on SUB->DONE
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_minus_b;
    logic             a_ge_b;

    assign a_minus_b = a_q - b_q;
    assign a_ge_b    = (a_q >= b_q);

`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
    localparam logic [WIDTH:0] ONE_C = (WIDTH+1)'(1);
    logic [WIDTH:0] cyc_cnt_q, cyc_cnt_d;
    logic [WIDTH:0] cycles_q, cycles_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
        cyc_cnt_d = cyc_cnt_q;
        cycles_d  = cycles_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
                    q_d     = '0;
                    dbz_d   = 1'b0;
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
                    cyc_cnt_d = '0;
`endif
                    state_d = SUB;
                end
            end
            SUB: begin
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
                cyc_cnt_d = cyc_cnt_q + ONE_C;
`endif
                if (b_q == '0) begin
                    q_d     = '1;
                    quot_d  = '1;
                    rem_d   = a_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
                    // include the current SUB cycle in the reported count
                    cycles_d = cyc_cnt_q + ONE_C;
`endif
                end else if (a_ge_b) begin
                    a_d = a_minus_b;
                    q_d = q_q + ONE_W;
                end else begin
                    quot_d  = q_q;
                    rem_d   = a_q;
                    state_d = DONE;
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
                    cycles_d = cyc_cnt_q + ONE_C;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cyc_cnt_q <= '0;
            cycles_q  <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            cycles_q  <= cycles_d;
        end
    end

    assign bus.cycles = cycles_q;
`endif

    // busy/done decode directly from the state flop, so clr drops them at once
    assign bus.busy        = (state_q == SUB);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sub_divider.sv
module tb_sub_divider;
    localparam int WIDTH = 8;
    localparam int MAX_EDGES = 600;

    logic clk = 1'b0;
    logic clr = 1'b1;

    sub_divider_if #(.WIDTH(WIDTH)) bus ();

    sub_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        int         busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation from an idle negedge. If poke > 0, a 7/7 start is
    // pulsed after edge number poke and again during the done cycle; both
    // must be ignored.
    task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input int poke);
        exp_t e;
        exp_t got_exp;
        int   edges;
        int   busy_cnt;
        e.q    = eq;
        e.r    = er;
        e.dbz  = edbz;
        e.lat  = edbz ? 2 : int'(eq) + 2;
        e.busy = edbz ? 1 : int'(eq) + 1;
        sb.push_back(e);

        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        edges    = 1;
        busy_cnt = 0;
        bus.start = 1'b0;
        while (!bus.done && edges < MAX_EDGES) begin
            if (bus.busy) busy_cnt++;
            if (poke > 0 && edges == poke) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd7;
                bus.divisor  = 8'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        got_exp = sb.pop_front();
        if (!bus.done) begin
            chk("done_timeout", 0, 1);
        end else begin
            $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d edges, busy %0d",
                     dvd, dvs, bus.quotient, bus.remainder, bus.div_by_zero, edges, busy_cnt);
            chk("quotient", int'(bus.quotient), int'(got_exp.q));
            chk("remainder", int'(bus.remainder), int'(got_exp.r));
            chk("div_by_zero", int'(bus.div_by_zero), int'(got_exp.dbz));
            chk("latency", edges, got_exp.lat);
            chk("busy_cycles", busy_cnt, got_exp.busy);
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
            chk("cycles", int'(bus.cycles), got_exp.busy);
`endif
            if (poke > 0) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd7;
                bus.divisor  = 8'd7;
            end
            @(negedge clk);
            bus.start = 1'b0;
            chk("done_one_cycle", int'(bus.done), 0);
            chk("idle_after_done", int'(bus.busy), 0);
            chk("result_hold_q", int'(bus.quotient), int'(got_exp.q));
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{dvd: 8'd13,  dvs: 8'd4,   q: 8'd3,   r: 8'd1,  dbz: 1'b0};
        vecs[1] = '{dvd: 8'd5,   dvs: 8'd7,   q: 8'd0,   r: 8'd5,  dbz: 1'b0};
        vecs[2] = '{dvd: 8'd9,   dvs: 8'd0,   q: 8'hFF,  r: 8'd9,  dbz: 1'b1};
        vecs[3] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
        vecs[4] = '{dvd: 8'd0,   dvs: 8'd5,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
        vecs[5] = '{dvd: 8'd250, dvs: 8'd16,  q: 8'd15,  r: 8'd10, dbz: 1'b0};
        vecs[6] = '{dvd: 8'd200, dvs: 8'd200, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
        vecs[7] = '{dvd: 8'd0,   dvs: 8'd0,   q: 8'hFF,  r: 8'd0,  dbz: 1'b1};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // reset state
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_dbz", int'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, 0);
        end

        // start during SUB and during DONE must be ignored
        run_op(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 3);
        // a start from IDLE afterwards is accepted
        run_op(8'd7, 8'd7, 8'd1, 8'd0, 1'b0, 0);
        // leave nonzero results behind so clr has something to clear
        run_op(8'd9, 8'd0, 8'hFF, 8'd9, 1'b1, 0);

        // clr in the middle of an operation
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_clr_busy", int'(bus.busy), 1);
        #3 clr = 1'b1;
        #1;
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_done", int'(bus.done), 0);
        chk("clr_quotient", int'(bus.quotient), 0);
        chk("clr_remainder", int'(bus.remainder), 0);
        chk("clr_dbz", int'(bus.div_by_zero), 0);
`ifdef SUB_DIVIDER_CYCLE_COUNT_EN
        chk("clr_cycles", int'(bus.cycles), 0);
`endif
        $display("clr asserted mid-operation: busy=%0d done=%0d q=%0d r=%0d",
                 bus.busy, bus.done, bus.quotient, bus.remainder);
        repeat (2) begin
            @(negedge clk);
            chk("clr_no_done", int'(bus.done), 0);
        end
        clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("after_clr_idle", int'(bus.done | bus.busy), 0);
        end
        run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
